// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the KGPminiRISC program-counter sequencer.
// Holds the FSM state encoding, jump condition codes and flag bit positions.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [2:0] COND_ALWAYS = 3'b000;
    localparam logic [2:0] COND_SIGN   = 3'b001;
    localparam logic [2:0] COND_ZERO   = 3'b010;
    localparam logic [2:0] COND_NZERO  = 3'b011;
    localparam logic [2:0] COND_CARRY  = 3'b100;
    localparam logic [2:0] COND_NCARRY = 3'b101;
    localparam logic [2:0] COND_RSVD6  = 3'b110;
    localparam logic [2:0] COND_RSVD7  = 3'b111;

    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_SIGN  = 0;

endpackage

// File: rtl/jump_cond_eval.sv
// Combinational jump condition evaluator: decides whether a conditional
// jump is taken given the current (possibly bypassed) flags.
module jump_cond_eval
    import pc_seq_pkg::*;
(
    input  logic [2:0] flags,
    input  logic [2:0] cond_jump,
    output logic       cond_ok
);

    // Reserved codes fall through to "never taken".
    always_comb begin
        cond_ok = 1'b0;
        case (cond_jump)
            COND_ALWAYS: cond_ok = 1'b1;
            COND_SIGN:   cond_ok = flags[FLAG_SIGN];
            COND_ZERO:   cond_ok = flags[FLAG_ZERO];
            COND_NZERO:  cond_ok = ~flags[FLAG_ZERO];
            COND_CARRY:  cond_ok = flags[FLAG_CARRY];
            COND_NCARRY: cond_ok = ~flags[FLAG_CARRY];
            default:     cond_ok = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC controller: FETCH -> EXEC -> UPDATE per instruction, with
// flag register, same-cycle flag bypass for jumps and a saturating taken counter.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                 ADDR_W   = 32,
    parameter int                 PC_INC   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic              exec_done,
    input  logic              is_branch,
    input  logic              is_halt,
    input  logic [2:0]        cond_jump,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              flag_we,
    input  logic [2:0]        flag_in,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        flags,
    output logic              taken,
    output logic              halted,
    output logic [CNT_W-1:0]  taken_cnt
);

    localparam logic [ADDR_W-1:0] LP_INC = ADDR_W'(PC_INC);

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_target;
    logic [2:0]        r_flags;
    logic              r_taken;
    logic              r_halted;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0]        w_eff_flags;
    logic              w_cond_ok;

    // A flag write in the exec_done cycle must be visible to that jump.
    assign w_eff_flags = flag_we ? flag_in : r_flags;

    jump_cond_eval u_cond_eval (
        .flags     (w_eff_flags),
        .cond_jump (cond_jump),
        .cond_ok   (w_cond_ok)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_target <= '0;
            r_flags  <= 3'b000;
            r_taken  <= 1'b0;
            r_halted <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_taken <= 1'b0;
            if (flag_we && (r_state != S_HALT)) begin
                r_flags <= flag_in;
            end
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Halt outranks a simultaneous branch: no PC update, no count.
                    if (exec_done) begin
                        r_target <= branch_target;
                        if (is_halt) begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end else begin
                            r_state <= S_UPDATE;
                            r_taken <= is_branch && w_cond_ok;
                        end
                    end
                end
                S_UPDATE: begin
                    r_pc <= r_taken ? r_target : (r_pc + LP_INC);
                    if (r_taken && (r_cnt != {CNT_W{1'b1}})) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem_req  = (r_state == S_FETCH) && rst;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign flags     = r_flags;
    assign taken     = r_taken;
    assign halted    = r_halted;
    assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: scoreboard of per-instruction results,
// a condition-code vector table and hand-written halt/wrap/reset sequences.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic        exec_done = 1'b0;
    logic        is_branch = 1'b0;
    logic        is_halt = 1'b0;
    logic [2:0]  cond_jump = 3'b000;
    logic [31:0] branch_target = 32'h0;
    logic        flag_we = 1'b0;
    logic [2:0]  flag_in = 3'b000;

    logic        imem_req, req2;
    logic [31:0] imem_addr, addr2;
    logic [31:0] pc, pc2;
    logic [2:0]  flags, flags2;
    logic        taken, taken2;
    logic        halted, halted2;
    logic [15:0] taken_cnt;
    logic [1:0]  cnt2;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] mPc;
    logic [2:0]  mFlags;
    int          mCnt;

    typedef struct {
        logic [31:0] nextPc;
        logic        taken;
        logic        halted;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [2:0]  preFlags;
        logic [2:0]  cond;
        logic [31:0] target;
        logic        expTaken;
    } vec_t;
    vec_t tbl[32];

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(32), .PC_INC(4), .RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .exec_done(exec_done), .is_branch(is_branch),
        .is_halt(is_halt), .cond_jump(cond_jump), .branch_target(branch_target),
        .flag_we(flag_we), .flag_in(flag_in), .pc(pc), .flags(flags),
        .taken(taken), .halted(halted), .taken_cnt(taken_cnt)
    );

    // Second instance with a 2-bit counter runs in lockstep to expose saturation.
    pc_sequencer #(.ADDR_W(32), .PC_INC(4), .RESET_PC(32'h0), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
        .imem_ack(imem_ack), .exec_done(exec_done), .is_branch(is_branch),
        .is_halt(is_halt), .cond_jump(cond_jump), .branch_target(branch_target),
        .flag_we(flag_we), .flag_in(flag_in), .pc(pc2), .flags(flags2),
        .taken(taken2), .halted(halted2), .taken_cnt(cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic condOk(input logic [2:0] c, input logic [2:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[0];
            3'd2:    return f[1];
            3'd3:    return !f[1];
            3'd4:    return f[2];
            3'd5:    return !f[2];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] sat2(input int c);
        return (c > 3) ? 2'd3 : c[1:0];
    endfunction

    task automatic clearInputs();
        imem_ack = 1'b0; exec_done = 1'b0; is_branch = 1'b0; is_halt = 1'b0;
        cond_jump = 3'b000; branch_target = 32'h0; flag_we = 1'b0; flag_in = 3'b000;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sbq.pop_front();
        @(negedge clk);
        check("taken_update", taken, e.taken);
        check("taken_update_dut2", taken2, e.taken);
        check("halted", halted, e.halted);
        check("halted_dut2", halted2, e.halted);
        check("imem_req_update", imem_req, 0);
        if (!e.halted) begin
            if (e.taken && mCnt < 65535) mCnt++;
            @(negedge clk);
            mPc = e.nextPc;
            check("pc_next", pc, mPc);
            check("pc_next_dut2", pc2, mPc);
            check("taken_cleared", taken, 0);
            check("taken_cnt", taken_cnt, mCnt);
            check("taken_cnt_sat2", cnt2, sat2(mCnt));
            check("flags", flags, mFlags);
            check("flags_dut2", flags2, mFlags);
            check("imem_req_fetch_again", imem_req, 1);
        end else begin
            check("pc_frozen_on_halt", pc, mPc);
            check("flags_on_halt", flags, mFlags);
        end
    endtask

    task automatic applyStimulus(input int ackDelay, input int execDelay, input logic br,
                                 input logic hlt, input logic [2:0] cj, input logic [31:0] tgt,
                                 input logic fwe, input logic [2:0] fin, input logic expTaken);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!imem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("imem_req_fetch", imem_req, 1);
        check("imem_req_fetch_dut2", req2, 1);
        check("imem_addr", imem_addr, mPc);
        check("imem_addr_dut2", addr2, mPc);
        // Stray exec_done/is_halt while fetching must have no effect.
        for (int i = 0; i < ackDelay; i++) begin
            exec_done = 1'b1; is_halt = 1'b1;
            @(posedge clk); #1;
            exec_done = 1'b0; is_halt = 1'b0;
            @(negedge clk);
            check("imem_req_hold", imem_req, 1);
        end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        for (int i = 0; i < execDelay; i++) begin
            imem_ack = 1'b1;
            @(negedge clk);
            check("imem_req_exec", imem_req, 0);
            @(posedge clk); #1;
            imem_ack = 1'b0;
        end
        exec_done = 1'b1; is_branch = br; is_halt = hlt; cond_jump = cj;
        branch_target = tgt; flag_we = fwe; flag_in = fin;
        e.halted = hlt;
        e.taken  = expTaken && !hlt;
        e.nextPc = hlt ? mPc : (e.taken ? tgt : mPc + 32'd4);
        if (fwe) mFlags = fin;
        sbq.push_back(e);
        @(negedge clk);
        check("imem_req_exec_done", imem_req, 0);
        @(posedge clk); #1;
        clearInputs();
        checkOutput();
    endtask

    task automatic runModel(input int ackDelay, input int execDelay, input logic br,
                            input logic hlt, input logic [2:0] cj, input logic [31:0] tgt,
                            input logic fwe, input logic [2:0] fin);
        logic [2:0] eff;
        eff = fwe ? fin : mFlags;
        applyStimulus(ackDelay, execDelay, br, hlt, cj, tgt, fwe, fin, br && condOk(cj, eff));
    endtask

    task automatic setFlags(input logic [2:0] f);
        flag_we = 1'b1; flag_in = f;
        @(posedge clk); #1;
        flag_we = 1'b0; flag_in = 3'b000;
        mFlags = f;
        @(negedge clk);
        check("flags_written", flags, f);
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearInputs();
        repeat (3) @(negedge clk);
        check("reset_pc", pc, 32'h0);
        check("reset_imem_req", imem_req, 0);
        check("reset_flags", flags, 0);
        check("reset_taken", taken, 0);
        check("reset_halted", halted, 0);
        check("reset_cnt", taken_cnt, 0);
        check("reset_cnt_dut2", cnt2, 0);
        mPc = 32'h0; mFlags = 3'b000; mCnt = 0;
        sbq.delete();
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] masks[4];
        logic [2:0] pres[4];
        int k;
        pres  = '{3'b000, 3'b001, 3'b010, 3'b100};
        masks = '{8'h29, 8'h2B, 8'h25, 8'h19};
        k = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 8; c++) begin
                tbl[k].preFlags = pres[p];
                tbl[k].cond     = 3'(c);
                tbl[k].target   = 32'h100 + 32'(k) * 32'h10;
                tbl[k].expTaken = masks[p][c];
                k++;
            end
        end

        doReset();

        // Sequential fetches with varied handshake latency.
        runModel(0, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        runModel(2, 1, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        runModel(1, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        runModel(0, 2, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        check("pc_after_four", pc, 32'd16);

        // Jump on zero after an earlier flag write.
        setFlags(3'b010);
        runModel(0, 0, 1, 0, 3'd2, 32'h40, 0, 3'b000);
        check("pc_jump_target", pc, 32'h40);
        check("cnt_after_first_jump", taken_cnt, 1);
        runModel(0, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);

        // Bypass: same-cycle flag write sets zero, so jump-if-not-zero falls through.
        setFlags(3'b000);
        runModel(0, 0, 1, 0, 3'd3, 32'h300, 1, 3'b010);
        check("flags_after_bypass", flags, 3'b010);

        // Condition-code table against fixed expected outcomes.
        for (int i = 0; i < 32; i++) begin
            setFlags(tbl[i].preFlags);
            applyStimulus(i % 2, i % 3, 1, 0, tbl[i].cond, tbl[i].target, 0, 3'b000,
                          tbl[i].expTaken);
        end

        // PC wrap at the top of the address space, plus more taken jumps.
        runModel(0, 0, 1, 0, 3'd0, 32'hFFFF_FFFC, 0, 3'b000);
        runModel(0, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        check("pc_wrap", pc, 32'h0);
        check("cnt2_saturated", cnt2, 2'd3);

        // Halt with branch: halt wins, then remains frozen.
        runModel(0, 0, 1, 1, 3'd0, 32'h80, 0, 3'b000);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                flag_we = 1'b1; flag_in = 3'b111; imem_ack = 1'b1; exec_done = 1'b1;
            end
            @(negedge clk);
            check("halt_imem_req", imem_req, 0);
            check("halt_pc", pc, mPc);
            check("halt_flags", flags, mFlags);
            check("halt_halted", halted, 1);
            check("halt_cnt", taken_cnt, mCnt);
            clearInputs();
        end

        // Reset asserted in the middle of an EXEC cycle.
        doReset();
        runModel(0, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        @(negedge clk);
        imem_ack = 1'b1;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        exec_done = 1'b1; is_branch = 1'b1; cond_jump = 3'd0;
        branch_target = 32'h200; flag_we = 1'b1; flag_in = 3'b111;
        #2 rst = 1'b0;
        #1;
        check("async_reset_pc", pc, 32'h0);
        check("async_reset_flags", flags, 0);
        check("async_reset_req", imem_req, 0);
        @(negedge clk);
        doReset();
        runModel(0, 0, 0, 0, 3'd0, 32'h0, 0, 3'b000);
        check("pc_after_reset_instr", pc, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
